// File: rtl/ir_transmitter_if.sv
// APB slave bundle shared between the IR frame transmitter and its bus master.
interface ir_transmitter_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/ir_transmitter.sv
// APB-programmable 11-bit pulse-width IR frame transmitter (start mark + 11 data marks, MSB first).
// Optional receiver-framing check on FRAME writes is enabled by defining IR_TX_FRAME_CHECK_EN.
module ir_transmitter #(
   parameter int unsigned START_MARK   = 100000,
   parameter int unsigned ONE_MARK     = 60000,
   parameter int unsigned ZERO_MARK    = 20000,
   parameter int unsigned SPACE        = 20000,
   parameter int unsigned CARRIER_HALF = 1316
) (
   input  logic            PCLK,
   input  logic            PRESET,
   ir_transmitter_if.slave apb,
   output logic            IR_LED,
   output logic            TX_ENV,
   output logic            TX_DONE
);

   localparam logic [7:0]  ADDR_FRAME  = 8'h00;
   localparam logic [7:0]  ADDR_STATUS = 8'h04;
   localparam logic [31:0] START_LAST  = 32'(START_MARK - 1);
   localparam logic [31:0] ONE_LAST    = 32'(ONE_MARK - 1);
   localparam logic [31:0] ZERO_LAST   = 32'(ZERO_MARK - 1);
   localparam logic [31:0] SPACE_LAST  = 32'(SPACE - 1);
   localparam logic [31:0] CAR_LAST    = 32'(CARRIER_HALF - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_SPACE,
      ST_MARK,
      ST_TAIL
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  bit_idx_q, bit_idx_d;
   logic [10:0] frame_q, frame_d;
   logic [31:0] car_cnt_q, car_cnt_d;
   logic        led_q, led_d;
   logic        tx_done_q, tx_done_d;
   logic        done_q, done_d;
   logic        overrun_q, overrun_d;
   logic        badframe_q, badframe_d;
   logic [31:0] prdata_q, prdata_d;

   logic        wr_stb;
   logic        rd_cap;
   logic        frame_wr;
   logic        status_rd;
   logic        busy;
   logic        frame_ok;
   logic        frame_start;
   logic [31:0] mark_last;
   logic        env_d;
   logic        mark_entry;
   logic        unused_pwdata;

   // ------------------------------------------------------------------
   // APB decode
   // ------------------------------------------------------------------
   assign wr_stb      = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign rd_cap      = apb.PSEL & ~apb.PWRITE;
   assign frame_wr    = wr_stb & (apb.PADDR == ADDR_FRAME);
   assign status_rd   = rd_cap & (apb.PADDR == ADDR_STATUS);
   assign busy        = (state_q != ST_IDLE);
   assign frame_start = frame_wr & ~busy & frame_ok;

`ifdef IR_TX_FRAME_CHECK_EN
   // Receiver framing: leading 2'b10 and trailing 2'b10.
   assign frame_ok = (apb.PWDATA[10:9] == 2'b10) && (apb.PWDATA[1:0] == 2'b10);
`else
   assign frame_ok = 1'b1;
`endif

   assign unused_pwdata = ^apb.PWDATA[31:11];

   assign apb.PRDATA  = prdata_q;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = 1'b0;

   // ------------------------------------------------------------------
   // Frame sequencer
   // ------------------------------------------------------------------
   assign mark_last = frame_q[bit_idx_q] ? ONE_LAST : ZERO_LAST;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 32'd1;
      bit_idx_d = bit_idx_q;
      frame_d   = frame_q;
      tx_done_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (frame_start) begin
               state_d   = ST_START;
               bit_idx_d = 4'd10;
               frame_d   = apb.PWDATA[10:0];
            end
         end
         ST_START: begin
            if (cnt_q == START_LAST) begin
               state_d = ST_SPACE;
               cnt_d   = '0;
            end
         end
         ST_SPACE: begin
            if (cnt_q == SPACE_LAST) begin
               state_d = ST_MARK;
               cnt_d   = '0;
            end
         end
         ST_MARK: begin
            if (cnt_q == mark_last) begin
               cnt_d = '0;
               if (bit_idx_q == 4'd0) begin
                  state_d = ST_TAIL;
               end else begin
                  bit_idx_d = bit_idx_q - 4'd1;
                  state_d   = ST_SPACE;
               end
            end
         end
         ST_TAIL: begin
            if (cnt_q == SPACE_LAST) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               tx_done_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Carrier: phase restarts high on every mark entry, held low in spaces
   // ------------------------------------------------------------------
   assign env_d      = (state_d == ST_START) || (state_d == ST_MARK);
   assign mark_entry = env_d && (state_d != state_q);

   always_comb begin
      led_d     = 1'b0;
      car_cnt_d = '0;
      if (mark_entry) begin
         led_d     = 1'b1;
         car_cnt_d = '0;
      end else if (env_d) begin
         if (car_cnt_q == CAR_LAST) begin
            led_d     = ~led_q;
            car_cnt_d = '0;
         end else begin
            led_d     = led_q;
            car_cnt_d = car_cnt_q + 32'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Sticky status: a same-cycle set beats the read-clear
   // ------------------------------------------------------------------
   always_comb begin
      done_d     = done_q;
      overrun_d  = overrun_q;
      badframe_d = badframe_q;
      if (status_rd) begin
         done_d     = 1'b0;
         overrun_d  = 1'b0;
         badframe_d = 1'b0;
      end
      if (tx_done_d) begin
         done_d = 1'b1;
      end
      if (frame_wr && busy) begin
         overrun_d = 1'b1;
      end
      if (frame_wr && !busy && !frame_ok) begin
         badframe_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Read-back register
   // ------------------------------------------------------------------
   always_comb begin
      prdata_d = prdata_q;
      if (rd_cap) begin
         case (apb.PADDR)
            ADDR_FRAME:  prdata_d = {21'd0, frame_q};
            ADDR_STATUS: prdata_d = {28'd0, badframe_q, overrun_q, done_q, busy};
            default:     prdata_d = '0;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         frame_q    <= '0;
         car_cnt_q  <= '0;
         led_q      <= 1'b0;
         tx_done_q  <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
         badframe_q <= 1'b0;
         prdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         frame_q    <= frame_d;
         car_cnt_q  <= car_cnt_d;
         led_q      <= led_d;
         tx_done_q  <= tx_done_d;
         done_q     <= done_d;
         overrun_q  <= overrun_d;
         badframe_q <= badframe_d;
         prdata_q   <= prdata_d;
      end
   end

   assign TX_ENV  = (state_q == ST_START) || (state_q == ST_MARK);
   assign IR_LED  = led_q;
   assign TX_DONE = tx_done_q;

endmodule

// File: doc/ir_transmitter.md
# ir_transmitter

APB-programmable IR frame transmitter: the sending end of the team's 11-bit pulse-width IR link. Software writes an 11-bit frame over APB. The block drives a carrier-modulated IR LED with a long start mark, followed by 11 data marks sent MSB first. Each data mark's length encodes its bit, and marks are separated by fixed carrier-off spaces. It sits beside the IR receiver on the same APB fabric, so one board can tag another.

## Interface
Parameters (cycles of PCLK; defaults assume 100 MHz):
- START_MARK, 100000, start mark length (receiver window 85000–115000)
- ONE_MARK, 60000, mark length for a 1 bit (receiver threshold ≥40000)
- ZERO_MARK, 20000, mark length for a 0 bit
- SPACE, 20000, carrier-off gap before each data bit and after the last bit
- CARRIER_HALF, 1316, carrier half-period (≈38 kHz)

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PADDR  in  8  APB address
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data, registered
- PREADY  out  1  tied 1
- PSLVERR  out  1  tied 0
- IR_LED  out  1  modulated LED drive
- TX_ENV  out  1  envelope, 1 during any mark
- TX_DONE  out  1  one-cycle pulse at frame end

## Operation
- Write strobe = PSEL && PENABLE && PWRITE.
- Read capture = PSEL && !PWRITE. PRDATA is loaded on this cycle.
- Registers:
  - 0x00 FRAME: W loads PWDATA[10:0] and starts a frame. R returns the last loaded frame in [10:0], zeros above.
  - 0x04 STATUS, read-only:
    - [0] BUSY
    - [1] DONE, sticky
    - [2] OVERRUN, sticky; a FRAME write arrived while BUSY
    - [3] BADFRAME, sticky; macro only
  - A read capture of STATUS clears bits [3:1].
  - Other addresses read 0; writes to them are ignored.
- FSM states: IDLE, START, SPACE, MARK, TAIL.
  - IDLE → START on an accepted FRAME write. bit_idx is set to 10 and the frame is latched.
  - START → SPACE after START_MARK cycles.
  - SPACE → MARK after SPACE cycles.
  - MARK lasts ONE_MARK or ZERO_MARK cycles, selected by frame[bit_idx]. At the end: if bit_idx==0 go to TAIL; otherwise decrement bit_idx and go to SPACE.
  - TAIL → IDLE after SPACE cycles. This transition pulses TX_DONE and sets DONE.
- TX_ENV = 1 in START and MARK, 0 otherwise.
- Carrier:
  - The counter restarts at every mark entry, and IR_LED=1 on the first mark cycle.
  - IR_LED toggles every CARRIER_HALF cycles while TX_ENV=1.
  - IR_LED=0 whenever TX_ENV=0.
- A FRAME write while BUSY is dropped. The frame register is unchanged and OVERRUN is set.
- If a sticky-bit set and a STATUS read clear occur in the same cycle, set wins.
- The phase-length counter is 32-bit unsigned. It compares against parameter−1, so there is no wrap-around.

## Timing
- Reset (PRESET high at a PCLK edge) forces:
  - all outputs to 0: IR_LED, TX_ENV, TX_DONE, PRDATA
  - state IDLE
  - FRAME register and STATUS to 0
- Reset mid-frame aborts immediately: no TX_DONE pulse and DONE is not set.
- Write accepted at edge N: BUSY=1, TX_ENV=1, IR_LED=1 from edge N+1.
- Frame duration = START_MARK + 11·SPACE + Σ marks + SPACE.
  - BUSY stays high exactly this many cycles.
  - TX_DONE is high for the single cycle following the last TAIL cycle, coincident with BUSY falling.
- A new write is accepted in the same cycle BUSY reads 0.
- PRDATA is valid in the APB access phase, one cycle after setup.

## Configuration
- Macro: IR_TX_FRAME_CHECK_EN.
- Defined: a FRAME write is accepted only if PWDATA[10:9]==2'b10 and PWDATA[1:0]==2'b10, matching the receiver's framing. A failing write starts nothing, leaves the FRAME register unchanged and sets BADFRAME.
- Undefined: any 11-bit value is transmitted, and STATUS[3] reads 0.

## Test plan
All scenarios use START_MARK=100, ONE_MARK=60, ZERO_MARK=20, SPACE=20, CARRIER_HALF=5.
- Nominal frame: write 0x596 to 0x00 → TX_ENV marks of 100, then 60,20,60,60,20,20,60,20,60,60,20, with 20-cycle spaces. BUSY high for 800 cycles, one TX_DONE pulse, then STATUS reads 0x2 once and 0x0 on the next read.
- Carrier: during the start mark, IR_LED is 1 for 5 cycles then 0 for 5, repeating 10 times. IR_LED is 0 in every space.
- Overrun: write 0x596, then write 0x402 at cycle 300 → transmission continues unchanged and STATUS reads 0x5. The read clears OVERRUN; the next read returns 0x1.
- Reset mid-frame: assert PRESET at cycle 400 for 1 cycle → IR_LED, TX_ENV and BUSY are 0 on the next cycle. No TX_DONE pulse, and FRAME reads 0.
- Macro defined: write 0x7FF → no transmission and STATUS reads 0x8. Then write 0x402 → 11 data marks: 60, then 20 ×8, then 60, 20.
- Loopback: drive an inverted TX_ENV into the IR receiver → the receiver's latched 11-bit data equals the frame written.
